// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: memory depth default, flag bit positions,
// and the control bundles carried through the M and W stages.
package pipeline_pkg;

    localparam int MEM_WORDS_DEFAULT = 64;

    // Bit positions inside the {N,Z,C,V} flag nibble
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic reg_write;
        logic mem_write;
        logic mem_to_reg;
        logic pc_src;
    } ctrl_m_t;

    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic pc_src;
    } ctrl_w_t;

endpackage

// File: rtl/data_memory.sv
// Word-addressed data memory: synchronous write, asynchronous read.
// A read in the same cycle as a write to that word returns the old contents.
module data_memory
    import pipeline_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_WORDS)-1:0] addr,
    input  logic [31:0]                  wdata,
    output logic [31:0]                  rdata
);

    logic [31:0] mem [MEM_WORDS];

    // NOTE: the array has no reset branch; clearing it would turn the RAM
    // into a bank of flops, and stored data must survive a pipeline reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// Memory and writeback stages: E->M and M->W pipeline registers, flag
// register, data memory and the writeback result mux.
module memory_stage
    import pipeline_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteEout,
    input  logic        MemWriteEout,
    input  logic        PCSrcEout,
    input  logic        MemtoRegE,
    input  logic        FlagWriteE,
    input  logic [3:0]  FlagsOut,
    input  logic [31:0] ALUResultE,
    input  logic [31:0] WriteDataE,
    input  logic [3:0]  WA3E,
    output logic [3:0]  FlagsE,
    output logic [31:0] ALUOutM,
    output logic        RegWriteM,
    output logic        RegWriteW,
    output logic [3:0]  WA3M,
    output logic [3:0]  WA3W,
    output logic [31:0] ResultW,
    output logic        PCSrcW
);

    localparam int AW = $clog2(MEM_WORDS);

    ctrl_m_t     ctrl_e;
    ctrl_m_t     ctrl_m;
    ctrl_w_t     ctrl_w;
    logic [31:0] alu_out_m;
    logic [31:0] write_data_m;
    logic [3:0]  wa3_m;
    logic [31:0] read_data_m;
    logic [31:0] read_data_w;
    logic [31:0] alu_out_w;
    logic [3:0]  wa3_w;
    logic [3:0]  flags;
    logic        mem_we;

    assign ctrl_e = '{
        reg_write:  RegWriteEout,
        mem_write:  MemWriteEout,
        mem_to_reg: MemtoRegE,
        pc_src:     PCSrcEout
    };

    // NOTE: state registers use non-blocking assignments so every stage
    // samples its predecessor's pre-edge value regardless of block order.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_m       <= '0;
            alu_out_m    <= '0;
            write_data_m <= '0;
            wa3_m        <= '0;
        end else begin
            ctrl_m       <= ctrl_e;
            alu_out_m    <= ALUResultE;
            write_data_m <= WriteDataE;
            wa3_m        <= WA3E;
        end
    end

    // Reset also kills a store already sitting in M
    assign mem_we = ctrl_m.mem_write & ~rst;

    data_memory #(
        .MEM_WORDS(MEM_WORDS)
    ) u_data_memory (
        .clk  (clk),
        .we   (mem_we),
        .addr (alu_out_m[AW+1:2]),
        .wdata(write_data_m),
        .rdata(read_data_m)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_w      <= '0;
            read_data_w <= '0;
            alu_out_w   <= '0;
            wa3_w       <= '0;
        end else begin
            ctrl_w      <= '{
                reg_write:  ctrl_m.reg_write,
                mem_to_reg: ctrl_m.mem_to_reg,
                pc_src:     ctrl_m.pc_src
            };
            read_data_w <= read_data_m;
            alu_out_w   <= alu_out_m;
            wa3_w       <= wa3_m;
        end
    end

    // No bypass: a flag update is seen by condition checks one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            flags <= 4'b0000;
        end else if (FlagWriteE) begin
            flags <= FlagsOut;
        end
    end

    assign FlagsE    = flags;
    assign ALUOutM   = alu_out_m;
    assign RegWriteM = ctrl_m.reg_write;
    assign WA3M      = wa3_m;
    assign RegWriteW = ctrl_w.reg_write;
    assign WA3W      = wa3_w;
    assign PCSrcW    = ctrl_w.pc_src;
    assign ResultW   = ctrl_w.mem_to_reg ? read_data_w : alu_out_w;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: the driver queues expected outputs with
// the cycle they are due; a negedge monitor pops and compares them.
module tb_memory_stage;
    import pipeline_pkg::*;

    typedef enum int {
        S_RESULT_W, S_WA3_W, S_REGWRITE_W, S_PCSRC_W,
        S_FLAGS_E, S_ALUOUT_M, S_REGWRITE_M, S_WA3_M
    } sel_e;

    typedef struct {
        int          due;
        sel_e        sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWriteEout, MemWriteEout, PCSrcEout, MemtoRegE, FlagWriteE;
    logic [3:0]  FlagsOut;
    logic [31:0] ALUResultE, WriteDataE;
    logic [3:0]  WA3E;
    logic [3:0]  FlagsE;
    logic [31:0] ALUOutM;
    logic        RegWriteM, RegWriteW;
    logic [3:0]  WA3M, WA3W;
    logic [31:0] ResultW;
    logic        PCSrcW;

    int   cyc = 0;
    int   ic;
    int   total = 0;
    int   bad = 0;
    exp_t sb[$];

    memory_stage #(.MEM_WORDS(64)) dut (
        .clk         (clk),
        .rst         (rst),
        .RegWriteEout(RegWriteEout),
        .MemWriteEout(MemWriteEout),
        .PCSrcEout   (PCSrcEout),
        .MemtoRegE   (MemtoRegE),
        .FlagWriteE  (FlagWriteE),
        .FlagsOut    (FlagsOut),
        .ALUResultE  (ALUResultE),
        .WriteDataE  (WriteDataE),
        .WA3E        (WA3E),
        .FlagsE      (FlagsE),
        .ALUOutM     (ALUOutM),
        .RegWriteM   (RegWriteM),
        .RegWriteW   (RegWriteW),
        .WA3M        (WA3M),
        .WA3W        (WA3W),
        .ResultW     (ResultW),
        .PCSrcW      (PCSrcW)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    function automatic logic [31:0] actual(sel_e s);
        case (s)
            S_RESULT_W:   return ResultW;
            S_WA3_W:      return {28'd0, WA3W};
            S_REGWRITE_W: return {31'd0, RegWriteW};
            S_PCSRC_W:    return {31'd0, PCSrcW};
            S_FLAGS_E:    return {28'd0, FlagsE};
            S_ALUOUT_M:   return ALUOutM;
            S_REGWRITE_M: return {31'd0, RegWriteM};
            default:      return {28'd0, WA3M};
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void expect_at(int due, sel_e s, logic [31:0] exp, string name);
        sb.push_back('{due: due, sel: s, exp: exp, name: name});
    endfunction

    // Monitor: compare every queued expectation that falls due this cycle
    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    check(sb[i].name, actual(sb[i].sel), sb[i].exp);
                    sb.delete(i);
                end
            end
        end
    end

    // Drive one instruction into E; it is in M at cycle ic+1 and W at ic+2
    task automatic issue(input logic r, input logic rw, input logic mw, input logic m2r,
                         input logic pcs, input logic fw, input logic [3:0] fl,
                         input logic [31:0] alu, input logic [31:0] wd, input logic [3:0] wa3);
        @(negedge clk);
        rst = r; RegWriteEout = rw; MemWriteEout = mw; MemtoRegE = m2r;
        PCSrcEout = pcs; FlagWriteE = fw; FlagsOut = fl;
        ALUResultE = alu; WriteDataE = wd; WA3E = wa3;
        ic = cyc;
    endtask

    task automatic issue_random_reset();
        issue(1'b1, 1'b1, 1'b1, $urandom_range(0, 1) == 1, 1'b1, 1'b1, 4'($urandom),
              32'h10, $urandom, 4'($urandom));
    endtask

    task automatic nop();
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic expect_all_zero(int due, string tag);
        expect_at(due, S_RESULT_W,   32'h0, {tag, "_result_w"});
        expect_at(due, S_WA3_W,      32'h0, {tag, "_wa3_w"});
        expect_at(due, S_REGWRITE_W, 32'h0, {tag, "_regwrite_w"});
        expect_at(due, S_PCSRC_W,    32'h0, {tag, "_pcsrc_w"});
        expect_at(due, S_FLAGS_E,    32'h0, {tag, "_flags_e"});
        expect_at(due, S_ALUOUT_M,   32'h0, {tag, "_aluout_m"});
        expect_at(due, S_REGWRITE_M, 32'h0, {tag, "_regwrite_m"});
        expect_at(due, S_WA3_M,      32'h0, {tag, "_wa3_m"});
    endtask

    task automatic expect_load(int c, logic [31:0] data, logic [3:0] wa3, string tag);
        expect_at(c + 2, S_RESULT_W,   data,           {tag, "_result_w"});
        expect_at(c + 2, S_WA3_W,      {28'd0, wa3},   {tag, "_wa3_w"});
        expect_at(c + 2, S_REGWRITE_W, 32'd1,          {tag, "_regwrite_w"});
    endtask

    initial begin
        logic [3:0] flags_z;
        logic [3:0] flags_n;
        flags_z = 4'b0000; flags_z[FLAG_Z] = 1'b1;
        flags_n = 4'b0000; flags_n[FLAG_N] = 1'b1;

        // Power-up reset, random inputs during both cycles
        issue_random_reset();
        issue_random_reset();
        expect_all_zero(ic + 1, "rst0");

        // Seed 0x10 with a known word
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h10, 32'h1234_5678, 4'h0);
        expect_at(ic + 2, S_REGWRITE_W, 32'd0, "seed_regwrite_w");
        nop();

        // Store to 0x10 caught in M by reset must not land
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h10, 32'hBAD0_BAD0, 4'h0);
        issue_random_reset();
        issue_random_reset();
        expect_all_zero(ic + 1, "rst1");
        issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 4'd7);
        expect_load(ic, 32'h1234_5678, 4'd7, "rst_nowrite");

        // Store then load, with M-stage visibility
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h10, 32'hDEAD_BEEF, 4'h0);
        issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 4'd5);
        expect_at(ic + 1, S_ALUOUT_M,   32'h10, "ld_aluout_m");
        expect_at(ic + 1, S_REGWRITE_M, 32'd1,  "ld_regwrite_m");
        expect_at(ic + 1, S_WA3_M,      32'd5,  "ld_wa3_m");
        expect_load(ic, 32'hDEAD_BEEF, 4'd5, "st_ld");

        // Same-cycle read/write returns the old word; next load sees the new
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h20, 32'h1, 4'h0);
        issue(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'h0, 32'h20, 32'h2, 4'd2);
        expect_load(ic, 32'h1, 4'd2, "rw_old");
        issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h20, 32'h0, 4'd3);
        expect_load(ic, 32'h2, 4'd3, "rw_new");

        // 0x103 wraps to word 0 and ignores byte offset
        issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 32'h103, 32'hA5A5_A5A5, 4'h0);
        issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h000, 32'h0, 4'd4);
        expect_load(ic, 32'hA5A5_A5A5, 4'd4, "wrap");

        // ALU result writeback with a PC write
        issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 32'hCAFE_0001, 32'h0, 4'd9);
        expect_load(ic, 32'hCAFE_0001, 4'd9, "alu_wb");
        expect_at(ic + 2, S_PCSRC_W, 32'd1, "alu_pcsrc_w");

        // Flags: load Z, then a disabled write of N must not disturb it
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, flags_z, 32'h0, 32'h0, 4'h0);
        expect_at(ic + 1, S_FLAGS_E, {28'd0, flags_z}, "flags_load");
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, flags_n, 32'h0, 32'h0, 4'h0);
        expect_at(ic + 1, S_FLAGS_E, {28'd0, flags_z}, "flags_hold");

        // Cancelled store leaves 0x10 intact and writes no register
        issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 32'h10, 32'h5, 4'd6);
        expect_at(ic + 2, S_REGWRITE_W, 32'd0, "cancel_regwrite_w");
        expect_at(ic + 2, S_PCSRC_W,    32'd0, "cancel_pcsrc_w");
        issue(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'h0, 32'h10, 32'h0, 4'd8);
        expect_load(ic, 32'hDEAD_BEEF, 4'd8, "cancel_mem");

        // Drain the scoreboard within a fixed cycle budget
        for (int i = 0; i < 8 && sb.size() > 0; i++) nop();
        nop();
        foreach (sb[i]) check({sb[i].name, "_never_sampled"}, 32'd1, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter MEM_WORDS, default 64, data-memory depth in 32-bit words (power of two).
REQ-002 clk  in  1  single rising-edge clock for all state.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 RegWriteEout, MemWriteEout, PCSrcEout  in  1 each  condition-qualified controls from execute.
REQ-005 MemtoRegE  in  1  select load data as writeback result.
REQ-006 FlagWriteE  in  1  condition-qualified flag-update enable.
REQ-007 FlagsOut  in  4  ALU flags {N,Z,C,V} from execute.
REQ-008 ALUResultE, WriteDataE  in  32 each  address/result and store data from execute.
REQ-009 WA3E  in  4  destination register from execute.
REQ-010 FlagsE  out  4  stored flags returned to execute condition check.
REQ-011 ALUOutM  out  32  M-stage ALU result for forwarding.
REQ-012 RegWriteM, RegWriteW  out  1 each  hazard-unit visibility of writes.
REQ-013 WA3M, WA3W  out  4 each  destination registers in M and W.
REQ-014 ResultW  out  32  writeback value to register file and forwarding.
REQ-015 PCSrcW  out  1  PC-write indication to fetch.

Function
REQ-016 E->M register SHALL capture RegWrite, MemWrite, MemtoReg, PCSrc, ALUResultE, WriteDataE, WA3E on every rising clk.
REQ-017 ALUOutM, RegWriteM, WA3M SHALL be driven directly from the E->M register, no combinational path from E inputs.
REQ-018 Data memory: word index = ALUOutM[log2(MEM_WORDS)+1:2]; bits [1:0] and upper bits ignored; addresses wrap modulo MEM_WORDS.
REQ-019 Store: when MemWriteM=1, WriteDataM SHALL be written at the rising clk ending the M cycle.
REQ-020 Load: read SHALL be combinational in M and captured into M->W register at the same edge (one-cycle load-to-W latency).
REQ-021 Same-cycle read/write to one address SHALL return the pre-write (old) word; the following instruction SHALL see new data.
REQ-022 M->W register SHALL capture RegWrite, MemtoReg, PCSrc, ReadData, ALUOut, WA3 on every rising clk.
REQ-023 ResultW = MemtoRegW ? ReadDataW : ALUOutW, combinational from W registers.
REQ-024 Flags register: 4-bit, loads FlagsOut at rising clk when FlagWriteE=1, else holds; FlagsE = register output.
REQ-025 No bypass of FlagsOut into FlagsE: a flag-setting instruction affects condition checks from the next instruction onward.
REQ-026 Controls reaching M as 0 (cancelled by condition or hazard flush upstream) SHALL cause no memory write and no register write; data fields may be arbitrary.

Reset
REQ-027 While rst=1 at a rising clk: all E->M and M->W registers SHALL clear to 0, flags register to 4'b0000.
REQ-028 After reset: RegWriteM=RegWriteW=PCSrcW=0, ALUOutM=0, WA3M=WA3W=0, ResultW=0, FlagsE=0.
REQ-029 rst SHALL suppress any memory write in the same cycle, including one mid-instruction; memory contents otherwise SHALL NOT be reset.

Structure
REQ-030 Shared package pipeline_pkg SHALL hold MEM_WORDS default, flag bit indices (N=3, Z=2, C=1, V=0), and a struct for M/W control bits.
REQ-031 Data memory SHALL be one sub-module, data_memory (sync write, async read, MEM_WORDS parameter).
REQ-032 Pipeline and flag registers SHALL live in memory_stage; total RTL 120-400 lines.

Verification
REQ-033 Reset: rst=1 two cycles with random inputs -> all outputs 0, no memory change at address 0x10.
REQ-034 Store/load: store 0xDEADBEEF to 0x10, next cycle load 0x10 with MemtoReg=1, WA3=5 -> two edges later ResultW=0xDEADBEEF, WA3W=5, RegWriteW=1.
REQ-035 Same-cycle conflict: word 0x20 holds 0x1, then store 0x2 to 0x20 -> load issued alongside the store at 0x20 returns 0x1; load issued the next cycle returns 0x2.
REQ-036 Wrap/alignment: store 0xA5A5A5A5 to 0x103 (MEM_WORDS=64) -> load from 0x000 returns 0xA5A5A5A5.
REQ-037 Flags: FlagsOut=4'b0100, FlagWriteE=1 -> FlagsE=4'b0100 next cycle; FlagsOut=4'b1000, FlagWriteE=0 -> FlagsE stays 4'b0100.
REQ-038 Cancelled store: MemWriteEout=0, ALUResultE=0x10, WriteDataE=0x5 -> word 0x10 unchanged, RegWriteW=0.
